// File: rtl/mi_nios_cpu_mul_pkg.sv
// Op codes and decode helpers for the Nios multiply writeback path.
// Defining MI_NIOS_MUL_ROTATE_EN makes op 4 (ROL) a legal, written-back op.
package mi_nios_cpu_mul_pkg;

    localparam int DATA_W_DFLT   = 32;
    localparam int REGNUM_W_DFLT = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULXSS = 3'd1,
        OP_MULXSU = 3'd2,
        OP_MULXUU = 3'd3,
        OP_ROL    = 3'd4
    } mul_op_e;

    typedef enum logic [1:0] {
        SLICE_LO = 2'd0,
        SLICE_HI = 2'd1,
        SLICE_OR = 2'd2
    } slice_e;

    typedef struct packed {
        logic   src1_signed;
        logic   src2_signed;
        slice_e slice;
        logic   legal;
    } mul_dec_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_MUL, OP_MULXSS, OP_MULXSU, OP_MULXUU: return 1'b1;
`ifdef MI_NIOS_MUL_ROTATE_EN
            OP_ROL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Illegal codes fall through to the plain MUL sign selection.
    function automatic logic op_src1_signed(input logic [2:0] op);
        case (op)
            OP_MULXUU: return 1'b0;
`ifdef MI_NIOS_MUL_ROTATE_EN
            OP_ROL: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic op_src2_signed(input logic [2:0] op);
        case (op)
            OP_MULXSU, OP_MULXUU: return 1'b0;
`ifdef MI_NIOS_MUL_ROTATE_EN
            OP_ROL: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic slice_e op_slice(input logic [2:0] op);
        case (op)
            OP_MULXSS, OP_MULXSU, OP_MULXUU: return SLICE_HI;
`ifdef MI_NIOS_MUL_ROTATE_EN
            OP_ROL: return SLICE_OR;
`endif
            default: return SLICE_LO;
        endcase
    endfunction

    function automatic mul_dec_t mul_decode(input logic [2:0] op);
        mul_dec_t d;
        d.src1_signed = op_src1_signed(op);
        d.src2_signed = op_src2_signed(op);
        d.slice       = op_slice(op);
        d.legal       = op_legal(op);
        return d;
    endfunction

endpackage

// File: rtl/mi_nios_cpu_mul_slot.sv
// One {valid, op, dst} pipeline slot that tracks a multiply alongside the cell's registers.
// Flush beats load; drain empties the slot when its entry moved on without a refill.
module mi_nios_cpu_mul_slot #(
    parameter int REGNUM_W = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                drain,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [2:0]          in_op,
    input  logic [REGNUM_W-1:0] in_dst,
    output logic                valid,
    output logic [2:0]          op,
    output logic [REGNUM_W-1:0] dst
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            op    <= '0;
            dst   <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= in_valid;
            else if (drain)
                valid <= 1'b0;

            if (load) begin
                op  <= in_op;
                dst <= in_dst;
            end
        end
    end

endmodule

// File: rtl/mi_nios_cpu_mul_wb.sv
// Multiply writeback companion: follows ops E->M->A with the cell, writes W, flags E-stage hazards.
// Defining MI_NIOS_MUL_ROTATE_EN enables the ROL op (result = hi | lo).
module mi_nios_cpu_mul_wb
    import mi_nios_cpu_mul_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int REGNUM_W = REGNUM_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  E_valid,
    input  logic [2:0]            E_mul_op,
    input  logic [REGNUM_W-1:0]   E_dst_regnum,
    input  logic [REGNUM_W-1:0]   E_src1_regnum,
    input  logic [REGNUM_W-1:0]   E_src2_regnum,
    output logic                  E_src1_signed,
    output logic                  E_src2_signed,
    input  logic                  M_en,
    input  logic                  A_en,
    input  logic                  A_kill,
    input  logic                  pipe_flush,
    input  logic [2*DATA_W-1:0]   A_mul_cell_result,
    output logic                  E_mul_hazard,
    output logic                  W_mul_wr_en,
    output logic [REGNUM_W-1:0]   W_mul_wr_regnum,
    output logic [DATA_W-1:0]     W_mul_wr_data
);

    logic                m_valid, a_valid;
    logic [2:0]          m_op, a_op;
    logic [REGNUM_W-1:0] m_dst, a_dst;
    logic                wr_term;

    function automatic logic [DATA_W-1:0] select_slice(input logic [2*DATA_W-1:0] prod,
                                                       input slice_e s);
        case (s)
            SLICE_HI: return prod[2*DATA_W-1:DATA_W];
            SLICE_OR: return prod[2*DATA_W-1:DATA_W] | prod[DATA_W-1:0];
            default:  return prod[DATA_W-1:0];
        endcase
    endfunction

    function automatic logic slot_hazard(input logic                v,
                                         input logic [2:0]          op,
                                         input logic [REGNUM_W-1:0] dst,
                                         input logic [REGNUM_W-1:0] s1,
                                         input logic [REGNUM_W-1:0] s2);
        return v && op_legal(op) && (dst != '0) && ((dst == s1) || (dst == s2));
    endfunction

    assign E_src1_signed = op_src1_signed(E_mul_op);
    assign E_src2_signed = op_src2_signed(E_mul_op);

    // E -> M: loads with the cell's operand register
    mi_nios_cpu_mul_slot #(.REGNUM_W(REGNUM_W)) u_m_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (M_en),
        .drain    (A_en & ~M_en),
        .flush    (pipe_flush),
        .in_valid (E_valid & ~pipe_flush),
        .in_op    (E_mul_op),
        .in_dst   (E_dst_regnum),
        .valid    (m_valid),
        .op       (m_op),
        .dst      (m_dst)
    );

    // M -> A: loads with the cell's product register
    mi_nios_cpu_mul_slot #(.REGNUM_W(REGNUM_W)) u_a_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (A_en),
        .drain    (1'b0),
        .flush    (pipe_flush),
        .in_valid (m_valid),
        .in_op    (m_op),
        .in_dst   (m_dst),
        .valid    (a_valid),
        .op       (a_op),
        .dst      (a_dst)
    );

    assign E_mul_hazard = slot_hazard(m_valid, m_op, m_dst, E_src1_regnum, E_src2_regnum)
                        | slot_hazard(a_valid, a_op, a_dst, E_src1_regnum, E_src2_regnum);

    assign wr_term = a_valid & A_en & ~A_kill & ~pipe_flush & op_legal(a_op);

    // A -> W: the product register holds the A-slot op's result while it sits in A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            W_mul_wr_en     <= 1'b0;
            W_mul_wr_regnum <= '0;
            W_mul_wr_data   <= '0;
        end else begin
            W_mul_wr_en <= wr_term;
            if (wr_term) begin
                W_mul_wr_regnum <= a_dst;
                W_mul_wr_data   <= select_slice(A_mul_cell_result, op_slice(a_op));
            end
        end
    end

endmodule
